// File: rtl/clock_div_by_1point5.sv
// ---------------------------------------------------------------------------
// clock_div_by_1point5
//
// Produces a clock at 2/3 of the input frequency. The output period is three
// half-periods of clk. A modulo-3 phase counter advances on every clk edge,
// both rising and falling. The output is a registered decode of that phase.
//
// Build option:
//   CLK_DIV_1P5_DUTY_INV_EN  undefined: out high while phase == 2 (1/3 duty)
//                            defined:   out high while phase != 2 (2/3 duty)
//
// Ports:
//   out    output  divided clock
//   clear  input   synchronous active-high reset, sampled on both clk edges
//   clk    input   input clock, both edges used
//
// Structure: each register is split into a rising-edge half and a
// falling-edge half. The logical value is the XOR of the two halves. On each
// edge only that edge's half is rewritten, so that
//     new_half = wanted_value ^ other_half.
// Because only one edge's flops change at any instant, the XOR-combined
// output cannot glitch. It also switches only coincident with a clk edge.
// ---------------------------------------------------------------------------
module clock_div_by_1point5 (
    output logic out,
    input  logic clear,
    input  logic clk
);

    // Gray-like encoding: 0->1 and 1->2 each flip a single bit.
    typedef enum logic [1:0] {
        PH0 = 2'b00,
        PH1 = 2'b01,
        PH2 = 2'b11
    } phase_t;

    // Declaration initialisers give every flop its reset value at power-up.
    // This keeps out defined from time 0, before the first clk edge.
    logic [1:0] ph_rise  = 2'b00;
    logic [1:0] ph_fall  = 2'b00;
    logic       out_rise = 1'b0;
    logic       out_fall = 1'b0;

    phase_t     phase;
    phase_t     phase_nxt;
    logic       out_nxt;

    assign phase = phase_t'(ph_rise ^ ph_fall);

    always_comb begin
        phase_nxt = PH0;
        case (phase)
            PH0:     phase_nxt = PH1;
            PH1:     phase_nxt = PH2;
            PH2:     phase_nxt = PH0;
            default: phase_nxt = PH0;   // unused code 2'b10 recovers to 0
        endcase
    end

    always_comb begin
`ifdef CLK_DIV_1P5_DUTY_INV_EN
        out_nxt = (phase_nxt != PH2);
`else
        out_nxt = (phase_nxt == PH2);
`endif
    end

    // Clear forces the logical value to zero by copying the other half.
    // The two halves of the XOR pair then cancel.
    always_ff @(posedge clk) begin
        if (clear) begin
            ph_rise  <= ph_fall;
            out_rise <= out_fall;
        end else begin
            ph_rise  <= phase_nxt ^ ph_fall;
            out_rise <= out_nxt ^ out_fall;
        end
    end

    always_ff @(negedge clk) begin
        if (clear) begin
            ph_fall  <= ph_rise;
            out_fall <= out_rise;
        end else begin
            ph_fall  <= phase_nxt ^ ph_rise;
            out_fall <= out_nxt ^ out_rise;
        end
    end

    assign out = out_rise ^ out_fall;

endmodule

// File: tb/tb_clock_div_by_1point5.sv
module tb_clock_div_by_1point5;

    localparam int N_EDGES = 600;

    logic clk;
    logic clear;
    logic out;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    clock_div_by_1point5 dut (
        .out   (out),
        .clear (clear),
        .clk   (clk)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: the phase counts clk edges modulo 3 and resets to 0 on clear.
    // The output level is a pure function of phase.
    function automatic bit ref_out(int ph, bit clr);
        if (clr) return 1'b0;
`ifdef CLK_DIV_1P5_DUTY_INV_EN
        return ph != 2;
`else
        return ph == 2;
`endif
    endfunction

    // Any change of out that is not on a clk edge is a glitch.
    // Edges fall on multiples of 5 ns.
    always @(out) begin
        if ($time > 0) begin
            checks++;
            if (($time % 5) != 0) begin
                errors++;
                $display("FAIL glitch: out changed at %0t, required only on clk edges", $time);
            end
        end
    end

    task automatic drive_and_model();
        int ph;
        bit clr_now;
        ph = 0;
        clear = 1'b1;
        #3 clear = 1'b0;
        for (int e = 0; e < N_EDGES; e++) begin
            @(clk);
            clr_now = clear;
            if (clr_now) ph = 0;
            else         ph = (ph + 1) % 3;
            exp_q.push_back(ref_out(ph, clr_now));
            #2;
            if (e < 40)
                clear = 1'b0;
            else if (e < 50)
                clear = 1'b1;
            else if (e < 90)
                clear = 1'b0;
            else if (ph == 1)
                // The next edge would put the phase at 2. This hits
                // out-high in the default build.
                clear = ($urandom_range(0, 3) == 0);
            else
                clear = ($urandom_range(0, 11) == 0);
        end
    endtask

    task automatic monitor();
        bit exp;
        #3;
        for (int e = 0; e < N_EDGES; e++) begin
            @(clk);
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: edge %0d at %0t, no expected value queued", e, $time);
            end else begin
                exp = exp_q.pop_front();
                if (out !== exp) begin
                    errors++;
                    $display("FAIL out_level: edge %0d at %0t got %b expected %b", e, $time, out, exp);
                end
            end
        end
    endtask

    initial begin
        // Out must be defined from power-up, before any edge.
        #1;
        checks++;
        if (out !== 1'b0) begin
            errors++;
            $display("FAIL powerup: out=%b at %0t expected 0", out, $time);
        end
    end

    initial begin
        fork
            drive_and_model();
            monitor();
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
